// File: rtl/bus_pkg.sv
// Shared result-bus types: the Result payload layout and the en/reject handshake helper.
package bus_pkg;

    typedef struct packed {
        logic        wb_valid;
        logic [4:0]  rd;
        logic [6:0]  rob_idx;
        logic [31:0] value;
        logic [3:0]  flags;
        logic [7:0]  exc;
    } Result;

    localparam int RESULT_W = $bits(Result);

    // A transfer happens when the sender requests and the receiver does not refuse.
    function automatic logic send_ok(input logic en, input logic reject);
        return en & ~reject;
    endfunction

endpackage

// File: rtl/msg_fifo.sv
// Per-channel message FIFO. Pointers wrap at DEPTH (any value >= 1); flush empties it synchronously.
module msg_fifo #(
    parameter int DEPTH = 2,
    parameter int MSG_W = 57,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [MSG_W-1:0] din,
    output logic [CNT_W-1:0] count,
    output logic [MSG_W-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [MSG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/result_bus_arbiter.sv
// N-channel buffered round-robin arbiter onto one shared result bus.
// Define RESULT_BUS_BYPASS_EN to let an empty channel's input reach the bus in the same cycle.
module result_bus_arbiter
    import bus_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int DEPTH = 2,
    parameter int MSG_W = RESULT_W
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  flush,
    input  logic [N_CH-1:0]                       in_en,
    input  logic [N_CH*MSG_W-1:0]                 in_msg,
    output logic [N_CH-1:0]                       in_reject,
    output logic                                  out_en,
    output logic [MSG_W-1:0]                      out_msg,
    output logic [$clog2(N_CH)-1:0]               out_ch,
    input  logic                                  out_reject,
    output logic [N_CH*$clog2(DEPTH+1)-1:0]       occupancy
);

    localparam int CH_W  = $clog2(N_CH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [OCC_W-1:0] cnt  [N_CH];
    logic [MSG_W-1:0] head [N_CH];
    logic [N_CH-1:0]  push, pop, full, nonempty, cand;

    logic [CH_W-1:0]  rr, lock_ch, grant, idx;
    logic             lock_valid, found, fire, bypass_sel;
    logic [MSG_W-1:0] sel_msg;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign full[c]     = (cnt[c] == OCC_W'(DEPTH));
        assign nonempty[c] = (cnt[c] != '0);
        assign occupancy[c*OCC_W +: OCC_W] = cnt[c];
        // A bypassed message that is accepted on the spot is never stored.
        assign push[c] = send_ok(in_en[c], in_reject[c])
                       & ~(bypass_sel & fire & (grant == CH_W'(c)));
        assign pop[c]  = fire & ~bypass_sel & (grant == CH_W'(c));

        msg_fifo #(.DEPTH(DEPTH), .MSG_W(MSG_W)) u_fifo (
            .clk   (clk),
            .rstn  (rstn),
            .flush (flush),
            .push  (push[c]),
            .pop   (pop[c]),
            .din   (in_msg[c*MSG_W +: MSG_W]),
            .count (cnt[c]),
            .head  (head[c])
        );
    end

    assign in_reject = full | {N_CH{flush}};

`ifdef RESULT_BUS_BYPASS_EN
    assign cand = nonempty | in_en;
`else
    assign cand = nonempty;
`endif

    // Round-robin search from rr+1; a held lock overrides the search entirely.
    always_comb begin
        grant = lock_valid ? lock_ch : rr;
        found = lock_valid;
        idx   = '0;
        if (!lock_valid) begin
            for (int i = 1; i <= N_CH; i++) begin
                idx = CH_W'((int'(rr) + i) % N_CH);
                if (!found && cand[idx]) begin
                    grant = idx;
                    found = 1'b1;
                end
            end
        end
    end

`ifdef RESULT_BUS_BYPASS_EN
    assign bypass_sel = found & ~lock_valid & ~nonempty[grant];
    assign sel_msg    = bypass_sel ? in_msg[grant*MSG_W +: MSG_W] : head[grant];
`else
    assign bypass_sel = 1'b0;
    assign sel_msg    = head[grant];
`endif

    assign out_en  = found & ~flush;
    assign out_ch  = out_en ? grant : '0;
    assign out_msg = out_en ? sel_msg : '0;
    assign fire    = send_ok(out_en, out_reject);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr         <= CH_W'(N_CH - 1);
            lock_valid <= 1'b0;
            lock_ch    <= '0;
        end else begin
            if (fire) rr <= grant;
            if (flush || fire) begin
                lock_valid <= 1'b0;
            end else if (out_en && out_reject) begin
                lock_valid <= 1'b1;
                lock_ch    <= grant;
            end
        end
    end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Directed scenario bench for result_bus_arbiter (default build, N_CH=4, DEPTH=2).
module tb_result_bus_arbiter;

    localparam int N_CH  = 4;
    localparam int DEPTH = 2;
    localparam int MSG_W = 57;
    localparam int OCC_W = 2;

    logic                    clk;
    logic                    rstn;
    logic                    flush;
    logic [N_CH-1:0]         in_en;
    logic [MSG_W-1:0]        msg_a [N_CH];
    logic [N_CH*MSG_W-1:0]   in_msg;
    logic [N_CH-1:0]         in_reject;
    logic                    out_en;
    logic [MSG_W-1:0]        out_msg;
    logic [1:0]              out_ch;
    logic                    out_reject;
    logic [N_CH*OCC_W-1:0]   occupancy;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q [$];
    logic [MSG_W-1:0] m0, m1, ma, mb, mc;

    assign in_msg = {msg_a[3], msg_a[2], msg_a[1], msg_a[0]};

    result_bus_arbiter #(.N_CH(N_CH), .DEPTH(DEPTH), .MSG_W(MSG_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .in_en      (in_en),
        .in_msg     (in_msg),
        .in_reject  (in_reject),
        .out_en     (out_en),
        .out_msg    (out_msg),
        .out_ch     (out_ch),
        .out_reject (out_reject),
        .occupancy  (occupancy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ev(input int ch, input logic [MSG_W-1:0] m);
        return 64'({2'(ch), m});
    endfunction

    function automatic logic [MSG_W-1:0] rnd_msg();
        return MSG_W'({$urandom(), $urandom()});
    endfunction

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn       = 1'b0;
        flush      = 1'b0;
        in_en      = '0;
        out_reject = 1'b0;
        for (int c = 0; c < N_CH; c++) msg_a[c] = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        exp_q.delete();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // scoreboard: every accepted output must match the head of the expected queue
    always @(negedge clk) begin
        if (rstn && out_en && !out_reject) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'd1, 64'd0);
            end else begin
                chk("out_data", 64'({out_ch, out_msg}), exp_q.pop_front());
            end
        end
    end

    initial begin
        do_reset();
        smp();
        chk("rst_out_en", 64'(out_en), 64'd0);
        chk("rst_in_reject", 64'(in_reject), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_out_ch", 64'(out_ch), 64'd0);
        chk("rst_out_msg", 64'(out_msg), 64'd0);

        // single message on channel 2: one cycle latency
        cyc();
        in_en = 4'b0100;
        msg_a[2] = MSG_W'(12'h0AB);
        exp_q.push_back(ev(2, MSG_W'(12'h0AB)));
        smp();
        chk("t1_no_bypass", 64'(out_en), 64'd0);
        cyc();
        in_en = '0;
        smp();
        chk("t1_out_en", 64'(out_en), 64'd1);
        chk("t1_out_ch", 64'(out_ch), 64'd2);
        chk("t1_out_msg", 64'(out_msg), 64'h0AB);
        cyc();
        smp();
        chk("t1_idle", 64'(out_en), 64'd0);

        // all four channels at once drain in channel order from reset priority
        do_reset();
        cyc();
        in_en = 4'b1111;
        for (int c = 0; c < N_CH; c++) begin
            msg_a[c] = rnd_msg();
            exp_q.push_back(ev(c, msg_a[c]));
        end
        cyc();
        in_en = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (k > 0) cyc();
            smp();
            chk("t2_out_en", 64'(out_en), 64'd1);
            chk("t2_out_ch", 64'(out_ch), 64'(k));
        end
        cyc();
        smp();
        chk("t2_idle", 64'(out_en), 64'd0);

        // lock: channel 1 rejected three cycles while channel 0 fills
        cyc();
        m1 = rnd_msg();
        in_en = 4'b0010;
        msg_a[1] = m1;
        out_reject = 1'b1;
        exp_q.push_back(ev(1, m1));
        cyc();
        m0 = rnd_msg();
        in_en = 4'b0001;
        msg_a[0] = m0;
        exp_q.push_back(ev(0, m0));
        smp();
        chk("t3_lock_ch_a", 64'(out_ch), 64'd1);
        chk("t3_lock_msg_a", 64'(out_msg), 64'(m1));
        cyc();
        in_en = '0;
        smp();
        chk("t3_lock_ch_b", 64'(out_ch), 64'd1);
        chk("t3_lock_msg_b", 64'(out_msg), 64'(m1));
        cyc();
        smp();
        chk("t3_lock_ch_c", 64'(out_ch), 64'd1);
        chk("t3_lock_msg_c", 64'(out_msg), 64'(m1));
        cyc();
        out_reject = 1'b0;
        smp();
        chk("t3_first_ch", 64'(out_ch), 64'd1);
        cyc();
        smp();
        chk("t3_second_ch", 64'(out_ch), 64'd0);
        drain("t3_drain");

        // channel 3 overfill against a stalled bus
        cyc();
        out_reject = 1'b1;
        ma = rnd_msg(); mb = rnd_msg(); mc = rnd_msg();
        in_en = 4'b1000;
        msg_a[3] = ma;
        exp_q.push_back(ev(3, ma));
        smp();
        chk("t4_push1_ok", 64'(in_reject[3]), 64'd0);
        cyc();
        msg_a[3] = mb;
        exp_q.push_back(ev(3, mb));
        smp();
        chk("t4_push2_ok", 64'(in_reject[3]), 64'd0);
        cyc();
        msg_a[3] = mc;
        smp();
        chk("t4_push3_rej", 64'(in_reject[3]), 64'd1);
        chk("t4_occ_full", 64'(occupancy[3*OCC_W +: OCC_W]), 64'd2);
        cyc();
        in_en = '0;
        smp();
        chk("t4_occ_hold", 64'(occupancy[3*OCC_W +: OCC_W]), 64'd2);
        chk("t4_head_msg", 64'(out_msg), 64'(ma));
        cyc();
        out_reject = 1'b0;
        smp();
        cyc();
        smp();
        cyc();
        smp();
        chk("t4_exactly_two", 64'(out_en), 64'd0);
        drain("t4_drain");

        // flush with buffered data and a concurrent push attempt
        cyc();
        out_reject = 1'b1;
        in_en = 4'b0101;
        msg_a[0] = rnd_msg(); msg_a[2] = rnd_msg();
        cyc();
        msg_a[0] = rnd_msg(); msg_a[2] = rnd_msg();
        smp();
        cyc();
        in_en = 4'b0010;
        msg_a[1] = rnd_msg();
        smp();
        chk("t5_pre_occ", 64'(occupancy), 64'h22);
        flush = 1'b1;
        #1;
        chk("t5_flush_out_en", 64'(out_en), 64'd0);
        chk("t5_flush_reject", 64'(in_reject), 64'hF);
        cyc();
        flush = 1'b0;
        in_en = '0;
        out_reject = 1'b0;
        smp();
        chk("t5_post_occ", 64'(occupancy), 64'd0);
        chk("t5_post_out_en", 64'(out_en), 64'd0);
        cyc();
        smp();
        chk("t5_ch1_not_stored", 64'(out_en), 64'd0);

        // async reset while a rejected output is locked
        cyc();
        out_reject = 1'b1;
        in_en = 4'b0110;
        msg_a[1] = rnd_msg(); msg_a[2] = rnd_msg();
        cyc();
        in_en = '0;
        smp();
        chk("t6_locked_ch", 64'(out_ch), 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk("t6_rst_out_en", 64'(out_en), 64'd0);
        chk("t6_rst_occ", 64'(occupancy), 64'd0);
        chk("t6_rst_in_reject", 64'(in_reject), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
        out_reject = 1'b0;
        cyc();
        in_en = 4'b1001;
        msg_a[0] = rnd_msg(); msg_a[3] = rnd_msg();
        exp_q.push_back(ev(0, msg_a[0]));
        exp_q.push_back(ev(3, msg_a[3]));
        cyc();
        in_en = '0;
        smp();
        chk("t6_first_prio", 64'(out_ch), 64'd0);
        cyc();
        smp();
        chk("t6_second", 64'(out_ch), 64'd3);
        drain("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
